// File: rtl/pipelined_switch_box.sv
// ---------------------------------------------------------------------------
// pipelined_switch_box
//
// Directional routing switch box for a routing tile. Each output track on
// each side (N=0, E=1, S=2, W=3) selects a track from one of the other three
// sides, or drives 0. The routing configuration is shifted serially into a
// shadow chain and copied into the active register in a single commit.
//
// Parameters
//   WS    tracks per side (>= 2)
//   MODE  0 = disjoint turns (same track index)
//         1 = Wilton turns (index rotated by +1 / -1 on turns)
//
// Ports
//   clk                        clock
//   rst                        synchronous active-high reset
//   n_in, e_in, s_in, w_in     input tracks per side   [WS-1:0]
//   n_out, e_out, s_out, w_out output tracks per side  [WS-1:0]
//   cfg_en                     shift one config bit this cycle
//   cfg_in                     serial config data
//   cfg_out                    shadow MSB, for daisy-chaining tiles
//   cfg_commit                 request copy shadow -> active
//   cfg_ack                    one-cycle pulse, commit accepted
//   cfg_err                    sticky, commit attempted before shadow full
//
// Build option
//   PIPELINED_SWITCH_BOX_OUT_REG_EN
//     defined   : outputs registered, one cycle input->output, reset to 0
//     undefined : outputs combinational from inputs and active config
// ---------------------------------------------------------------------------
module pipelined_switch_box #(
    parameter int WS   = 8,
    parameter int MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WS-1:0] n_in,
    input  logic [WS-1:0] e_in,
    input  logic [WS-1:0] s_in,
    input  logic [WS-1:0] w_in,
    output logic [WS-1:0] n_out,
    output logic [WS-1:0] e_out,
    output logic [WS-1:0] s_out,
    output logic [WS-1:0] w_out,
    input  logic          cfg_en,
    input  logic          cfg_in,
    output logic          cfg_out,
    input  logic          cfg_commit,
    output logic          cfg_ack,
    output logic          cfg_err
);

    localparam int CW    = 8 * WS;
    localparam int CNT_W = $clog2(CW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    shadow;
    logic [CW-1:0]    active;

    logic [WS-1:0] in_p0  [4];
    logic [WS-1:0] out_p0 [4];

    // Track index feeding output track k for a given non-zero select.
    // Straight (10) always keeps the index; turns rotate only in Wilton mode.
    function automatic int src_idx(input int k, input logic [1:0] sel);
        if (sel == 2'b10 || MODE == 0)
            return k;
        else if (sel == 2'b01)
            return (k + 1) % WS;
        else
            return (k + WS - 1) % WS;
    endfunction

    assign cfg_out = shadow[CW-1];

    // Loader: commit has priority over shifting, so a same-cycle commit
    // captures the pre-shift shadow and the shift is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            cnt     <= '0;
            shadow  <= '0;
            active  <= '0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            if (cfg_commit) begin
                if (state == FULL) begin
                    active  <= shadow;
                    cnt     <= '0;
                    state   <= EMPTY;
                    cfg_ack <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (cfg_en) begin
                shadow <= {shadow[CW-2:0], cfg_in};
                if (state != FULL) begin
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_LAST) ? FULL : LOADING;
                end
            end
        end
    end

    // Stage p0: combinational routing from inputs and active config
    assign in_p0[0] = n_in;
    assign in_p0[1] = e_in;
    assign in_p0[2] = s_in;
    assign in_p0[3] = w_in;

    always_comb begin
        logic [1:0] sel;
        sel = 2'b00;
        for (int x = 0; x < 4; x++) begin
            out_p0[x] = '0;
            for (int k = 0; k < WS; k++) begin
                sel = active[(x*WS + k)*2 +: 2];
                if (sel != 2'b00)
                    out_p0[x][k] = in_p0[(x + int'(sel)) % 4][src_idx(k, sel)];
            end
        end
    end

`ifdef PIPELINED_SWITCH_BOX_OUT_REG_EN
    // Stage p1: registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            n_out <= '0;
            e_out <= '0;
            s_out <= '0;
            w_out <= '0;
        end else begin
            n_out <= out_p0[0];
            e_out <= out_p0[1];
            s_out <= out_p0[2];
            w_out <= out_p0[3];
        end
    end
`else
    assign n_out = out_p0[0];
    assign e_out = out_p0[1];
    assign s_out = out_p0[2];
    assign w_out = out_p0[3];
`endif

endmodule
